// File: rtl/waypoint_sequencer_pkg.sv
// Shared types and defaults for the waypoint record/playback sequencer.
package waypoint_sequencer_pkg;

    localparam int COORD_W   = 8;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_DWELL = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_DWELL
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
        logic [COORD_W-1:0] g;
    } pose_t;

endpackage

// File: rtl/waypoint_sequencer_axis_stepper.sv
// One axis position register: loads directly or steps one LSB toward target.
module axis_stepper
    import waypoint_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [COORD_W-1:0] load_val,
    input  logic               step_en,
    input  logic [COORD_W-1:0] target,
    output logic [COORD_W-1:0] pos,
    output logic               eq
);

    assign eq = (pos == target);

    // Stepping only toward the target means the register can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= '0;
        end else if (load) begin
            pos <= load_val;
        end else if (step_en) begin
            if (pos < target) begin
                pos <= pos + 1'b1;
            end else if (pos > target) begin
                pos <= pos - 1'b1;
            end
        end
    end

endmodule

// File: rtl/waypoint_sequencer.sv
// Records manual poses and plays them back one LSB per step tick.
module waypoint_sequencer
    import waypoint_sequencer_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int DWELL = DEF_DWELL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_en,
    input  logic [COORD_W-1:0] man_x,
    input  logic [COORD_W-1:0] man_y,
    input  logic [COORD_W-1:0] man_z,
    input  logic [COORD_W-1:0] man_g,
    input  logic               rec,
    input  logic               play,
    input  logic               stop,
    input  logic               clear,
    input  logic               loop_en,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [COORD_W-1:0] out_z,
    output logic [COORD_W-1:0] out_g,
    output logic               busy,
    output logic               at_target,
    output logic [IDX_W-1:0]   wp_idx,
    output logic [IDX_W:0]     wp_count,
    output logic               full
);

    localparam int CNT_W = $clog2(DWELL + 1);

    pose_t            wp [DEPTH];
    pose_t            tgt;
    pose_t            man;
    state_t           state;
    logic [CNT_W-1:0] dwell_cnt;
    logic [3:0]       eq;
    logic             all_eq;
    logic             idle;
    logic             load;
    logic             step;
    logic             do_clear;
    logic             do_play;
    logic             do_rec;

    assign man    = '{x: man_x, y: man_y, z: man_z, g: man_g};
    assign tgt    = wp[wp_idx];
    assign all_eq = &eq;
    assign idle   = (state == S_IDLE);
    assign busy   = !idle;
    assign full   = (wp_count == (IDX_W+1)'(DEPTH));

    assign at_target = busy && all_eq;

    // clear always pairs with stop so an abort can also wipe the program
    assign do_clear = clear && (idle || stop);
    assign do_play  = idle && !stop && !clear && play
                      && (wp_count != '0);
    assign do_rec   = idle && !stop && !clear && !do_play
                      && rec && !full;

    assign load = idle;
    assign step = step_en && (state == S_MOVE) && !stop;

    axis_stepper u_x (
        .clk(clk), .rst(rst), .load(load), .load_val(man.x),
        .step_en(step), .target(tgt.x), .pos(out_x), .eq(eq[0])
    );
    axis_stepper u_y (
        .clk(clk), .rst(rst), .load(load), .load_val(man.y),
        .step_en(step), .target(tgt.y), .pos(out_y), .eq(eq[1])
    );
    axis_stepper u_z (
        .clk(clk), .rst(rst), .load(load), .load_val(man.z),
        .step_en(step), .target(tgt.z), .pos(out_z), .eq(eq[2])
    );
    axis_stepper u_g (
        .clk(clk), .rst(rst), .load(load), .load_val(man.g),
        .step_en(step), .target(tgt.g), .pos(out_g), .eq(eq[3])
    );

    // Waypoint storage is deliberately not reset; wp_count gates access.
    always_ff @(posedge clk) begin
        if (!rst && do_rec) begin
            wp[wp_count[IDX_W-1:0]] <= man;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wp_idx    <= '0;
            wp_count  <= '0;
            dwell_cnt <= '0;
        end else begin
            if (do_clear) begin
                wp_count <= '0;
            end else if (do_rec) begin
                wp_count <= wp_count + 1'b1;
            end
            if (stop) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (do_play) begin
                            wp_idx <= '0;
                            state  <= S_MOVE;
                        end
                    end
                    S_MOVE: begin
                        if (all_eq) begin
                            dwell_cnt <= '0;
                            state     <= S_DWELL;
                        end
                    end
                    S_DWELL: begin
                        if (dwell_cnt == CNT_W'(DWELL)) begin
                            if ({1'b0, wp_idx} < wp_count - 1'b1) begin
                                wp_idx <= wp_idx + 1'b1;
                                state  <= S_MOVE;
                            end else if (loop_en) begin
                                wp_idx <= '0;
                                state  <= S_MOVE;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else if (step_en) begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_waypoint_sequencer.sv
// Directed scoreboard bench for waypoint_sequencer.
module tb_waypoint_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       step_en;
    logic [7:0] man_x, man_y, man_z, man_g;
    logic       rec, play, stop, clear, loop_en;
    logic [7:0] out_x, out_y, out_z, out_g;
    logic       busy, at_target;
    logic [2:0] wp_idx;
    logic [3:0] wp_count;
    logic       full;

    int tests = 0;
    int fails = 0;

    string       tq[$];
    logic [31:0] vq[$];

    waypoint_sequencer #(.DEPTH(8), .DWELL(2)) dut (
        .clk(clk), .rst(rst), .step_en(step_en),
        .man_x(man_x), .man_y(man_y), .man_z(man_z), .man_g(man_g),
        .rec(rec), .play(play), .stop(stop), .clear(clear),
        .loop_en(loop_en),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_g(out_g),
        .busy(busy), .at_target(at_target), .wp_idx(wp_idx),
        .wp_count(wp_count), .full(full)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [31:0] v);
        tq.push_back(t);
        vq.push_back(v);
    endtask

    task automatic cmp(input logic [31:0] obs);
        string       t;
        logic [31:0] v;
        t = tq.pop_front();
        v = vq.pop_front();
        tests++;
        assert (obs === v) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", t, obs, v);
        end
    endtask

    task automatic set_man(input logic [7:0] x, y, z, g);
        man_x = x; man_y = y; man_z = z; man_g = g;
    endtask

    task automatic pulse_clear;
        clear = 1'b1; tick; clear = 1'b0;
    endtask

    task automatic wait_idx_change(output logic [31:0] v);
        logic [2:0] p;
        p = wp_idx;
        v = 32'hFFFF_FFFF;
        for (int i = 0; i < 200; i++) begin
            tick;
            if (wp_idx != p) begin
                v = 32'(wp_idx);
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        bit          hit;
        rst = 1'b1; step_en = 1'b0;
        rec = 1'b0; play = 1'b0; stop = 1'b0;
        clear = 1'b0; loop_en = 1'b0;
        set_man(0, 0, 0, 0);
        tick; tick;
        push("rst_out_x", 0);     cmp(32'(out_x));
        push("rst_busy", 0);      cmp(32'(busy));
        push("rst_count", 0);     cmp(32'(wp_count));
        push("rst_idx", 0);       cmp(32'(wp_idx));
        push("rst_at_target", 0); cmp(32'(at_target));
        rst = 1'b0;

        set_man(10, 20, 30, 40);
        push("man_x", 10); push("man_y", 20);
        push("man_z", 30); push("man_g", 40);
        tick; tick;
        cmp(32'(out_x)); cmp(32'(out_y));
        cmp(32'(out_z)); cmp(32'(out_g));
        push("idle_busy", 0);  cmp(32'(busy));
        push("idle_count", 0); cmp(32'(wp_count));

        // Nine records into eight slots; slot i holds x = i
        for (int i = 0; i < 9; i++) begin
            set_man(8'(i), 0, 0, 0);
            rec = 1'b1;
            tick;
        end
        rec = 1'b0;
        push("rec_count", 8); cmp(32'(wp_count));
        push("rec_full", 1);  cmp(32'(full));

        set_man(0, 0, 0, 0);
        tick; tick;
        play = 1'b1; tick; play = 1'b0;
        step_en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick;
            if (wp_idx == 3'd7 && at_target) hit = 1'b1;
        end
        push("slot7_reached", 1); cmp(32'(hit));
        push("slot7_x", 7);       cmp(32'(out_x));
        step_en = 1'b0;
        stop = 1'b1; tick; stop = 1'b0;

        pulse_clear;
        push("clear_count", 0); cmp(32'(wp_count));

        // Single waypoint, stepping every 4 cycles
        set_man(5, 0, 0, 0);
        rec = 1'b1; tick; rec = 1'b0;
        set_man(2, 0, 0, 0);
        tick; tick;
        push("start_x", 2); cmp(32'(out_x));
        play = 1'b1; tick; play = 1'b0;
        push("play_busy", 1); cmp(32'(busy));
        for (int s = 3; s <= 5; s++) begin
            tick; tick; tick;
            step_en = 1'b1; tick; step_en = 1'b0;
            push($sformatf("step_x_%0d", s), 32'(s));
            cmp(32'(out_x));
        end
        push("at_target", 1); cmp(32'(at_target));
        tick;
        push("dwell_busy", 1); cmp(32'(busy));
        for (int p = 0; p < 2; p++) begin
            tick; tick; tick;
            step_en = 1'b1; tick; step_en = 1'b0;
            push($sformatf("dwell_hold_%0d", p), 5);
            cmp(32'(out_x));
        end
        push("dwell_busy_last", 1); cmp(32'(busy));
        tick;
        push("done_idle", 0); cmp(32'(busy));

        // Two waypoints with looping
        pulse_clear;
        set_man(10, 0, 0, 0);
        rec = 1'b1; tick;
        set_man(12, 0, 0, 0);
        tick; rec = 1'b0;
        set_man(10, 0, 0, 0);
        tick; tick;
        loop_en = 1'b1;
        step_en = 1'b1;
        play = 1'b1; tick; play = 1'b0;
        push("loop_idx0", 0); cmp(32'(wp_idx));
        wait_idx_change(v); push("loop_idx1", 1);  cmp(v);
        wait_idx_change(v); push("loop_idx0b", 0); cmp(v);
        wait_idx_change(v); push("loop_idx1b", 1); cmp(v);

        set_man(77, 0, 0, 0);
        stop = 1'b1; tick; stop = 1'b0;
        push("stop_idle", 0);  cmp(32'(busy));
        push("stop_idx", 1);   cmp(32'(wp_idx));
        tick;
        push("stop_track", 77); cmp(32'(out_x));

        // play and rec together: play wins
        set_man(20, 0, 0, 0);
        play = 1'b1; rec = 1'b1; tick;
        play = 1'b0; rec = 1'b0;
        push("playrec_busy", 1);  cmp(32'(busy));
        push("playrec_count", 2); cmp(32'(wp_count));
        stop = 1'b1; clear = 1'b1; tick;
        stop = 1'b0; clear = 1'b0;
        push("stopclr_busy", 0);  cmp(32'(busy));
        push("stopclr_count", 0); cmp(32'(wp_count));

        // Saturation toward 255
        step_en = 1'b0;
        set_man(255, 0, 0, 0);
        rec = 1'b1; tick; rec = 1'b0;
        set_man(250, 0, 0, 0);
        tick; tick;
        push("sat_start", 250); cmp(32'(out_x));
        play = 1'b1; tick; play = 1'b0;
        step_en = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        push("sat_5", 255); cmp(32'(out_x));
        for (int i = 0; i < 5; i++) tick;
        step_en = 1'b0;
        push("sat_10", 255); cmp(32'(out_x));
        push("sat_busy", 1); cmp(32'(busy));

        rst = 1'b1; tick; rst = 1'b0;
        push("midrst_busy", 0);  cmp(32'(busy));
        push("midrst_count", 0); cmp(32'(wp_count));
        push("midrst_out", 0);   cmp(32'(out_x));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
